// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU control path and the
// debug/program-loader port. It grants one requester at a time, uses
// round-robin on contention, latches the winning request, and returns a
// one-cycle acknowledge with registered read data. A watchdog ends any
// transfer the memory never acknowledges and flags it with an error.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpuReq,
    input  logic                cpuWe,
    input  logic [ADDR_W-1:0]   cpuAddr,
    input  logic [DATA_W-1:0]   cpuWdata,
    input  logic [DATA_W/8-1:0] cpuBe,
    output logic                cpuAck,
    output logic                cpuErr,
    output logic [DATA_W-1:0]   cpuRdata,
    input  logic                dbgReq,
    input  logic                dbgWe,
    input  logic [ADDR_W-1:0]   dbgAddr,
    input  logic [DATA_W-1:0]   dbgWdata,
    input  logic [DATA_W/8-1:0] dbgBe,
    output logic                dbgAck,
    output logic                dbgErr,
    output logic [DATA_W-1:0]   dbgRdata,
    output logic                memReq,
    output logic                memWe,
    output logic [ADDR_W-1:0]   memAddr,
    output logic [DATA_W-1:0]   memWdata,
    output logic [DATA_W/8-1:0] memBe,
    input  logic [DATA_W-1:0]   memRdata,
    input  logic                memAck,
    output logic [1:0]          grant
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT_CPU = 2'b01,
        GNT_DBG = 2'b10
    } state_t;

    state_t           state;
    logic             lastGrant;
    logic [CNT_W-1:0] wdogCnt;
    logic [CNT_W-1:0] cntNext;
    logic             timeoutHit;

    // The state encoding is the one-hot grant code, so grant comes straight off the state register
    assign grant = state;

    // Watchdog fires when the cycle now ending would be grant cycle number TIMEOUT
    always_comb begin
        cntNext    = wdogCnt + 1'b1;
        timeoutHit = 1'b0;
        if ((TIMEOUT != 0) && (cntNext == CNT_W'(TIMEOUT))) begin
            timeoutHit = 1'b1;
        end
    end

    // Arbitration FSM with latched request fields, watchdog and registered ack/err/rdata
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            wdogCnt   <= '0;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= '0;
            memWdata  <= '0;
            memBe     <= '0;
            cpuAck    <= 1'b0;
            cpuErr    <= 1'b0;
            cpuRdata  <= '0;
            dbgAck    <= 1'b0;
            dbgErr    <= 1'b0;
            dbgRdata  <= '0;
        end else begin
            cpuAck   <= 1'b0;
            cpuErr   <= 1'b0;
            cpuRdata <= '0;
            dbgAck   <= 1'b0;
            dbgErr   <= 1'b0;
            dbgRdata <= '0;
            case (state)
                IDLE: begin
                    wdogCnt <= '0;
                    if (cpuReq && (!dbgReq || lastGrant)) begin
                        state     <= GNT_CPU;
                        lastGrant <= 1'b0;
                        memReq    <= 1'b1;
                        memWe     <= cpuWe;
                        memAddr   <= cpuAddr;
                        memWdata  <= cpuWdata;
                        memBe     <= cpuBe;
                    end else if (dbgReq) begin
                        state     <= GNT_DBG;
                        lastGrant <= 1'b1;
                        memReq    <= 1'b1;
                        memWe     <= dbgWe;
                        memAddr   <= dbgAddr;
                        memWdata  <= dbgWdata;
                        memBe     <= dbgBe;
                    end
                end
                GNT_CPU, GNT_DBG: begin
                    if (memAck) begin
                        state   <= IDLE;
                        memReq  <= 1'b0;
                        wdogCnt <= '0;
                        if (state == GNT_CPU) begin
                            cpuAck   <= 1'b1;
                            cpuRdata <= memRdata;
                        end else begin
                            dbgAck   <= 1'b1;
                            dbgRdata <= memRdata;
                        end
                    end else if (timeoutHit) begin
                        state   <= IDLE;
                        memReq  <= 1'b0;
                        wdogCnt <= '0;
                        if (state == GNT_CPU) begin
                            cpuAck <= 1'b1;
                            cpuErr <= 1'b1;
                        end else begin
                            dbgAck <= 1'b1;
                            dbgErr <= 1'b1;
                        end
                    end else begin
                        wdogCnt <= cntNext;
                    end
                end
                default: begin
                    state  <= IDLE;
                    memReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a small watchdog
// limit so timeouts are quick to reach.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        cpuReq, cpuWe, dbgReq, dbgWe;
    logic [31:0] cpuAddr, cpuWdata, dbgAddr, dbgWdata;
    logic [3:0]  cpuBe, dbgBe;
    logic        cpuAck, cpuErr, dbgAck, dbgErr;
    logic [31:0] cpuRdata, dbgRdata;
    logic        memReq, memWe, memAck;
    logic [31:0] memAddr, memWdata, memRdata;
    logic [3:0]  memBe;
    logic [1:0]  grant;

    int checks = 0;
    int passes = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata), .cpuBe(cpuBe),
        .cpuAck(cpuAck), .cpuErr(cpuErr), .cpuRdata(cpuRdata),
        .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWdata(dbgWdata), .dbgBe(dbgBe),
        .dbgAck(dbgAck), .dbgErr(dbgErr), .dbgRdata(dbgRdata),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe),
        .memRdata(memRdata), .memAck(memAck), .grant(grant)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cpuReq = 0; cpuWe = 0; cpuAddr = '0; cpuWdata = '0; cpuBe = '0;
        dbgReq = 0; dbgWe = 0; dbgAddr = '0; dbgWdata = '0; dbgBe = '0;
        memAck = 0; memRdata = '0;
        step(); step();
        checks++; if ({memReq, memWe, grant} !== 4'b0) $display("[TB] FAIL reset ctrl: got %b expected 0000", {memReq, memWe, grant}); else passes++;
        checks++; if ({cpuAck, cpuErr, dbgAck, dbgErr} !== 4'b0) $display("[TB] FAIL reset acks: got %b expected 0000", {cpuAck, cpuErr, dbgAck, dbgErr}); else passes++;
        checks++; if ({memAddr, memWdata, memBe} !== 68'b0) $display("[TB] FAIL reset mem fields: got %h expected 0", {memAddr, memWdata, memBe}); else passes++;
        checks++; if ({cpuRdata, dbgRdata} !== 64'b0) $display("[TB] FAIL reset rdata: got %h expected 0", {cpuRdata, dbgRdata}); else passes++;
        rst = 1'b1;
        step();
    endtask

    task automatic test_cpu_read();
        cpuReq = 1; cpuWe = 0; cpuAddr = 32'h40;
        step();
        checks++; if (grant !== 2'b01) $display("[TB] FAIL cpu_read grant: got %b expected 01", grant); else passes++;
        checks++; if (memReq !== 1'b1) $display("[TB] FAIL cpu_read memReq: got %b expected 1", memReq); else passes++;
        checks++; if (memAddr !== 32'h40) $display("[TB] FAIL cpu_read memAddr: got %h expected 40", memAddr); else passes++;
        memAck = 1; memRdata = 32'hDEADBEEF;
        step();
        memAck = 0; memRdata = '0;
        checks++; if (cpuAck !== 1'b1) $display("[TB] FAIL cpu_read ack: got %b expected 1", cpuAck); else passes++;
        checks++; if (cpuRdata !== 32'hDEADBEEF) $display("[TB] FAIL cpu_read rdata: got %h expected deadbeef", cpuRdata); else passes++;
        checks++; if ({cpuErr, dbgAck, grant, memReq} !== 5'b0) $display("[TB] FAIL cpu_read post: got %b expected 00000", {cpuErr, dbgAck, grant, memReq}); else passes++;
        cpuReq = 0;
        step();
        checks++; if ({cpuAck, cpuRdata} !== 33'b0) $display("[TB] FAIL cpu_read pulse: got %h expected 0", {cpuAck, cpuRdata}); else passes++;
    endtask

    task automatic test_contention();
        logic        lastModel;
        logic        winDbg;
        logic [31:0] rd;
        rst = 0; step(); rst = 1; step();
        lastModel = 1'b1;
        cpuReq = 1; dbgReq = 1; cpuWe = 0; dbgWe = 0;
        cpuAddr = $urandom; dbgAddr = $urandom;
        step();
        for (int i = 0; i < 6; i++) begin
            winDbg = !lastModel;
            lastModel = winDbg;
            checks++; if (grant !== (winDbg ? 2'b10 : 2'b01)) $display("[TB] FAIL contention grant %0d: got %b expected %b", i, grant, winDbg ? 2'b10 : 2'b01); else passes++;
            checks++; if (memAddr !== (winDbg ? dbgAddr : cpuAddr)) $display("[TB] FAIL contention addr %0d: got %h expected %h", i, memAddr, winDbg ? dbgAddr : cpuAddr); else passes++;
            rd = $urandom;
            memAck = 1; memRdata = rd;
            step();
            memAck = 0;
            checks++; if ({cpuAck, dbgAck} !== (winDbg ? 2'b01 : 2'b10)) $display("[TB] FAIL contention acks %0d: got %b expected %b", i, {cpuAck, dbgAck}, winDbg ? 2'b01 : 2'b10); else passes++;
            checks++; if ((winDbg ? dbgRdata : cpuRdata) !== rd) $display("[TB] FAIL contention rdata %0d: got %h expected %h", i, winDbg ? dbgRdata : cpuRdata, rd); else passes++;
            step();
        end
        cpuReq = 0; dbgReq = 0; memAck = 1;
        step();
        memAck = 0;
        step();
    endtask

    task automatic test_dbg_write_latch();
        dbgReq = 1; dbgWe = 1; dbgAddr = 32'h100; dbgWdata = 32'h12345678; dbgBe = 4'hF;
        step();
        checks++; if (grant !== 2'b10) $display("[TB] FAIL dbg_write grant: got %b expected 10", grant); else passes++;
        checks++; if ({memWe, memBe, memWdata} !== {1'b1, 4'hF, 32'h12345678}) $display("[TB] FAIL dbg_write fields: got %h expected %h", {memWe, memBe, memWdata}, {1'b1, 4'hF, 32'h12345678}); else passes++;
        dbgAddr = 32'h200; dbgWdata = 32'hCAFEF00D; dbgBe = 4'h1;
        step();
        checks++; if (memAddr !== 32'h100) $display("[TB] FAIL dbg_write addr hold: got %h expected 100", memAddr); else passes++;
        checks++; if ({memWdata, memBe} !== {32'h12345678, 4'hF}) $display("[TB] FAIL dbg_write data hold: got %h expected %h", {memWdata, memBe}, {32'h12345678, 4'hF}); else passes++;
        memAck = 1;
        step();
        memAck = 0;
        checks++; if ({dbgAck, dbgErr, cpuAck} !== 3'b100) $display("[TB] FAIL dbg_write ack: got %b expected 100", {dbgAck, dbgErr, cpuAck}); else passes++;
        dbgReq = 0;
        step();
    endtask

    task automatic test_timeout();
        int n;
        cpuReq = 1; cpuWe = 0; cpuAddr = 32'h80; memRdata = 32'hBAD0BAD0;
        step();
        n = 0;
        while (memReq === 1'b1 && n < 20) begin
            n++;
            step();
        end
        checks++; if (n !== TO) $display("[TB] FAIL timeout memReq cycles: got %0d expected %0d", n, TO); else passes++;
        checks++; if ({cpuAck, cpuErr} !== 2'b11) $display("[TB] FAIL timeout ack/err: got %b expected 11", {cpuAck, cpuErr}); else passes++;
        checks++; if (cpuRdata !== 32'h0) $display("[TB] FAIL timeout rdata: got %h expected 0", cpuRdata); else passes++;
        checks++; if (grant !== 2'b00) $display("[TB] FAIL timeout grant: got %b expected 00", grant); else passes++;
        cpuReq = 0; memRdata = '0;
        step();
        checks++; if ({cpuAck, cpuErr} !== 2'b00) $display("[TB] FAIL timeout pulse: got %b expected 00", {cpuAck, cpuErr}); else passes++;
    endtask

    task automatic test_ack_at_limit();
        cpuReq = 1; cpuWe = 0; cpuAddr = 32'hC0;
        step();
        repeat (TO - 1) step();
        memAck = 1; memRdata = 32'h5A5AA5A5;
        step();
        memAck = 0; memRdata = '0;
        checks++; if ({cpuAck, cpuErr} !== 2'b10) $display("[TB] FAIL ack_at_limit ack/err: got %b expected 10", {cpuAck, cpuErr}); else passes++;
        checks++; if (cpuRdata !== 32'h5A5AA5A5) $display("[TB] FAIL ack_at_limit rdata: got %h expected 5a5aa5a5", cpuRdata); else passes++;
        cpuReq = 0;
        step();
    endtask

    task automatic test_idle_ack();
        memAck = 1; memRdata = 32'h11111111;
        step();
        memAck = 0; memRdata = '0;
        checks++; if ({cpuAck, dbgAck, memReq, grant} !== 5'b0) $display("[TB] FAIL idle_ack: got %b expected 00000", {cpuAck, dbgAck, memReq, grant}); else passes++;
        step();
    endtask

    task automatic test_reset_mid_grant();
        logic sawAck;
        cpuReq = 1; cpuWe = 1; cpuAddr = 32'h3C; cpuWdata = 32'h77; cpuBe = 4'h3;
        step();
        checks++; if (memReq !== 1'b1) $display("[TB] FAIL reset_mid memReq before: got %b expected 1", memReq); else passes++;
        #2 rst = 0;
        #1;
        checks++; if ({memReq, memWe, grant, cpuAck} !== 5'b0) $display("[TB] FAIL reset_mid ctrl: got %b expected 00000", {memReq, memWe, grant, cpuAck}); else passes++;
        checks++; if ({memAddr, memWdata, memBe} !== 68'b0) $display("[TB] FAIL reset_mid fields: got %h expected 0", {memAddr, memWdata, memBe}); else passes++;
        step();
        rst = 1; cpuReq = 0;
        sawAck = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (cpuAck !== 1'b0 || dbgAck !== 1'b0) sawAck = 1;
        end
        checks++; if (sawAck !== 1'b0) $display("[TB] FAIL reset_mid stray ack: got %b expected 0", sawAck); else passes++;
        cpuReq = 1; dbgReq = 1; cpuWe = 0; dbgWe = 0;
        step();
        checks++; if (grant !== 2'b01) $display("[TB] FAIL reset_mid tie: got %b expected 01", grant); else passes++;
        cpuReq = 0; dbgReq = 0; memAck = 1;
        step();
        memAck = 0;
        step();
    endtask

    task automatic test_random();
        logic        lastModel, winDbg, expErr, holdOk;
        int          kind, delay, ackWin;
        logic [31:0] cA, dA, cD, dD, rd, expAddr, expData;
        logic [3:0]  cB, dB, expBe;
        logic        cW, dW, expWe;
        rst = 0; step(); rst = 1; step();
        lastModel = 1'b1;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            cA = $urandom; dA = $urandom; cD = $urandom; dD = $urandom;
            cB = 4'($urandom_range(0, 15)); dB = 4'($urandom_range(0, 15));
            cW = 1'($urandom_range(0, 1)); dW = 1'($urandom_range(0, 1));
            cpuReq = (kind != 1); dbgReq = (kind != 0);
            cpuAddr = cA; cpuWdata = cD; cpuBe = cB; cpuWe = cW;
            dbgAddr = dA; dbgWdata = dD; dbgBe = dB; dbgWe = dW;
            if (kind == 2) winDbg = !lastModel;
            else winDbg = (kind == 1);
            lastModel = winDbg;
            expAddr = winDbg ? dA : cA; expData = winDbg ? dD : cD;
            expBe = winDbg ? dB : cB; expWe = winDbg ? dW : cW;
            delay = $urandom_range(1, 6);
            rd = $urandom;
            expErr = (delay > TO);
            ackWin = expErr ? TO + 1 : delay + 1;
            step();
            checks++; if (grant !== (winDbg ? 2'b10 : 2'b01)) $display("[TB] FAIL random grant t=%0d: got %b expected %b", t, grant, winDbg ? 2'b10 : 2'b01); else passes++;
            checks++; if ({memWe, memAddr, memWdata, memBe} !== {expWe, expAddr, expData, expBe}) $display("[TB] FAIL random fields t=%0d: got %h expected %h", t, {memWe, memAddr, memWdata, memBe}, {expWe, expAddr, expData, expBe}); else passes++;
            cpuAddr = $urandom; dbgAddr = $urandom; cpuWdata = $urandom; dbgWdata = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                if (winDbg) dbgReq = 0;
                else cpuReq = 0;
            end
            holdOk = 1;
            for (int j = 1; j < ackWin; j++) begin
                if (memReq !== 1'b1 || memAddr !== expAddr || cpuAck !== 1'b0 || dbgAck !== 1'b0 || cpuRdata !== 32'h0 || dbgRdata !== 32'h0) holdOk = 0;
                memAck = (j == delay);
                memRdata = (j == delay) ? rd : $urandom;
                step();
            end
            memAck = 0;
            checks++; if (holdOk !== 1'b1) $display("[TB] FAIL random hold t=%0d: got %b expected 1", t, holdOk); else passes++;
            checks++; if ({cpuAck, dbgAck} !== (winDbg ? 2'b01 : 2'b10)) $display("[TB] FAIL random acks t=%0d: got %b expected %b", t, {cpuAck, dbgAck}, winDbg ? 2'b01 : 2'b10); else passes++;
            checks++; if ((winDbg ? dbgErr : cpuErr) !== expErr) $display("[TB] FAIL random err t=%0d: got %b expected %b", t, winDbg ? dbgErr : cpuErr, expErr); else passes++;
            checks++; if ((winDbg ? dbgRdata : cpuRdata) !== (expErr ? 32'h0 : rd)) $display("[TB] FAIL random rdata t=%0d: got %h expected %h", t, winDbg ? dbgRdata : cpuRdata, expErr ? 32'h0 : rd); else passes++;
            checks++; if ({memReq, grant, (winDbg ? cpuRdata : dbgRdata)} !== 35'b0) $display("[TB] FAIL random idle t=%0d: got %h expected 0", t, {memReq, grant, (winDbg ? cpuRdata : dbgRdata)}); else passes++;
            cpuReq = 0; dbgReq = 0;
            step();
        end
    endtask

    // Hard stop in case anything stalls
    initial begin
        #2000000;
        $display("[TB] FAIL global time limit: simulation still running");
        $fatal(1, "[TB] time limit");
    end

    // Scenario sequence
    initial begin
        test_reset();
        test_cpu_read();
        test_contention();
        test_dbg_write_latch();
        test_timeout();
        test_ack_at_limit();
        test_idle_ack();
        test_reset_mid_grant();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
